// File: rtl/board_store.sv
// board_store
//
// Double-buffered cell store for the generation engine. The engine reads
// the current generation and writes the next generation into the other
// bank. The banks swap once the engine writes the final word of the board
// after at least one other write. A display port reads the current bank,
// and an edit port lets the user change cells in the current bank.
// A clear sweep zeroes both banks after every reset and on each rising
// edge of start.
//
// Ports:
//   clk             clock
//   rst             asynchronous active-high reset; starts a clear sweep
//   start           rising edge starts a clear sweep
//   wden            engine write enable
//   round_write_pos engine write address (next bank)
//   live            engine write data
//   round_read_pos  engine read address (current bank)
//   round_read_val  engine read data, one cycle after the address
//   edit_en         user edit write enable
//   edit_pos        edit address (current bank)
//   edit_val        edit data
//   disp_pos        display read address (current bank)
//   disp_val        display read data, one cycle after the address
//   busy            clear sweep in progress
//   gen_done        one-cycle pulse when the banks have swapped
//   gen_count       number of completed generations, wraps

module board_store #(
    parameter int P_PARAM_M = 5,
    parameter int READ_COL  = 5,
    parameter int WIDTH     = 12,
    parameter int BLOCK_LEN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   wden,
    input  logic [2*WIDTH-1:0]     round_write_pos,
    input  logic [BLOCK_LEN-1:0]   live,
    input  logic [2*WIDTH-1:0]     round_read_pos,
    output logic [BLOCK_LEN-1:0]   round_read_val,
    input  logic                   edit_en,
    input  logic [2*WIDTH-1:0]     edit_pos,
    input  logic [BLOCK_LEN-1:0]   edit_val,
    input  logic [2*WIDTH-1:0]     disp_pos,
    output logic [BLOCK_LEN-1:0]   disp_val,
    output logic                   busy,
    output logic                   gen_done,
    output logic [WIDTH-1:0]       gen_count
);

    localparam int DEPTH = P_PARAM_M * READ_COL;
    localparam int AW    = $clog2(2 * DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2*WIDTH-1:0] DEPTH_A  = (2*WIDTH)'(DEPTH);
    localparam logic [2*WIDTH-1:0] LAST_A   = (2*WIDTH)'(DEPTH - 1);
    localparam logic [CW-1:0]      CLR_LAST = CW'(DEPTH - 1);
    localparam logic [AW-1:0]      BANK_OFS = AW'(DEPTH);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          clr_addr_q, clr_addr_d;
    logic                   bank_q, bank_d;
    logic                   armed_q, armed_d;
    logic                   swap_pend_q, swap_pend_d;
    logic                   start_q;
    logic                   gen_done_q, gen_done_d;
    logic [WIDTH-1:0]       gen_count_q, gen_count_d;
    logic [BLOCK_LEN-1:0]   rd_val_q, rd_val_d;
    logic [BLOCK_LEN-1:0]   disp_val_q, disp_val_d;
    logic [BLOCK_LEN-1:0]   mem_q [2*DEPTH];
    logic [BLOCK_LEN-1:0]   mem_d [2*DEPTH];

    logic                   start_edge;
    logic                   wr_ok;
    logic                   edit_ok;

    // Flat word index: bank 1 occupies the upper DEPTH words.
    function automatic logic [AW-1:0] word_idx(input logic b,
                                                input logic [2*WIDTH-1:0] a);
        word_idx = (b ? BANK_OFS : '0) + a[AW-1:0];
    endfunction

    assign start_edge = start && !start_q;
    assign wr_ok      = wden && (round_write_pos < DEPTH_A);
    assign edit_ok    = edit_en && (edit_pos < DEPTH_A);

    // Next-state logic. A start edge overrides everything, including a
    // swap that is waiting to commit. A commit is recorded on the cycle
    // the final word is written and applied on the following edge, so
    // reads sampled at that later edge still see the old bank.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        bank_d      = bank_q;
        armed_d     = armed_q;
        swap_pend_d = swap_pend_q;
        gen_done_d  = 1'b0;
        gen_count_d = gen_count_q;
        rd_val_d    = '0;
        disp_val_d  = '0;
        mem_d       = mem_q;

        if (start_edge) begin
            state_d     = CLEAR;
            clr_addr_d  = '0;
            bank_d      = 1'b0;
            armed_d     = 1'b0;
            swap_pend_d = 1'b0;
            gen_count_d = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    mem_d[AW'(clr_addr_q)]            = '0;
                    mem_d[AW'(clr_addr_q) + BANK_OFS] = '0;
                    if (clr_addr_q == CLR_LAST) begin
                        state_d    = RUN;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + CW'(1);
                    end
                end
                RUN: begin
                    if (round_read_pos < DEPTH_A) begin
                        rd_val_d = mem_q[word_idx(bank_q, round_read_pos)];
                    end
                    if (disp_pos < DEPTH_A) begin
                        disp_val_d = mem_q[word_idx(bank_q, disp_pos)];
                    end

                    if (swap_pend_q) begin
                        bank_d      = ~bank_q;
                        gen_count_d = gen_count_q + WIDTH'(1);
                        gen_done_d  = 1'b1;
                        swap_pend_d = 1'b0;
                    end

                    // Arming is cleared as soon as the commit is taken so a
                    // held write to the last word cannot commit twice.
                    if (wr_ok) begin
                        mem_d[word_idx(~bank_q, round_write_pos)] = live;
                        if (round_write_pos == LAST_A) begin
                            if (armed_q) begin
                                swap_pend_d = 1'b1;
                                armed_d     = 1'b0;
                            end
                        end else begin
                            armed_d = 1'b1;
                        end
                    end

                    if (edit_ok) begin
                        mem_d[word_idx(bank_q, edit_pos)] = edit_val;
                    end
                end
                default: begin
                    state_d = CLEAR;
                end
            endcase
        end
    end

    // Control and output registers; reset launches a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            bank_q      <= 1'b0;
            armed_q     <= 1'b0;
            swap_pend_q <= 1'b0;
            start_q     <= 1'b0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
            rd_val_q    <= '0;
            disp_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            bank_q      <= bank_d;
            armed_q     <= armed_d;
            swap_pend_q <= swap_pend_d;
            start_q     <= start;
            gen_done_q  <= gen_done_d;
            gen_count_q <= gen_count_d;
            rd_val_q    <= rd_val_d;
            disp_val_q  <= disp_val_d;
        end
    end

    // Cell storage has no reset; the clear sweep defines its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign round_read_val = rd_val_q;
    assign disp_val       = disp_val_q;
    assign busy           = (state_q == CLEAR);
    assign gen_done       = gen_done_q;
    assign gen_count      = gen_count_q;

endmodule

// File: tb/tb_board_store.sv
// tb_board_store
//
// Directed bench for board_store with the default 5x5 board (25 words).
// Each task drives one scenario and compares outputs against
// hand-computed values.

module tb_board_store;

    localparam int WIDTH = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 wden;
    logic [2*WIDTH-1:0]   round_write_pos;
    logic [0:0]           live;
    logic [2*WIDTH-1:0]   round_read_pos;
    logic [0:0]           round_read_val;
    logic                 edit_en;
    logic [2*WIDTH-1:0]   edit_pos;
    logic [0:0]           edit_val;
    logic [2*WIDTH-1:0]   disp_pos;
    logic [0:0]           disp_val;
    logic                 busy;
    logic                 gen_done;
    logic [WIDTH-1:0]     gen_count;

    int checks = 0;
    int errors = 0;

    board_store dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .wden            (wden),
        .round_write_pos (round_write_pos),
        .live            (live),
        .round_read_pos  (round_read_pos),
        .round_read_val  (round_read_val),
        .edit_en         (edit_en),
        .edit_pos        (edit_pos),
        .edit_val        (edit_val),
        .disp_pos        (disp_pos),
        .disp_val        (disp_val),
        .busy            (busy),
        .gen_done        (gen_done),
        .gen_count       (gen_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        start = 1'b0;
        wden = 1'b0;
        round_write_pos = '0;
        live = '0;
        round_read_pos = '0;
        edit_en = 1'b0;
        edit_pos = '0;
        edit_val = '0;
        disp_pos = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b1 || gen_done !== 1'b0 || gen_count !== '0 ||
            round_read_val !== 1'b0 || disp_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: busy=%b gen_done=%b gen_count=%0d rd=%b disp=%b, required 1 0 0 0 0",
                     busy, gen_done, gen_count, round_read_val, disp_val);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n !== 25) begin
            errors++;
            $display("[TB] FAIL reset_sweep_len: got %0d cycles, required 25", n);
        end
        round_read_pos = 24'd13;
        disp_pos = 24'd24;
        step();
        checks++;
        if (round_read_val !== 1'b0 || disp_val !== 1'b0 || gen_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_reads: rd=%b disp=%b gen_count=%0d, required 0 0 0",
                     round_read_val, disp_val, gen_count);
        end
    endtask

    task automatic test_edit();
        edit_en = 1'b1;
        edit_pos = 24'd7;
        edit_val = 1'b1;
        step();
        // Edit pos 9 while reading pos 9 in the same cycle: old value first.
        edit_pos = 24'd9;
        round_read_pos = 24'd9;
        disp_pos = 24'd9;
        step();
        edit_en = 1'b0;
        checks++;
        if (round_read_val !== 1'b0 || disp_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_first: rd=%b disp=%b, required 0 0", round_read_val, disp_val);
        end
        round_read_pos = 24'd7;
        disp_pos = 24'd7;
        step();
        checks++;
        if (round_read_val !== 1'b1 || disp_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL edit_read7: rd=%b disp=%b, required 1 1", round_read_val, disp_val);
        end
        round_read_pos = 24'd8;
        disp_pos = 24'd9;
        step();
        checks++;
        if (round_read_val !== 1'b0 || disp_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL edit_read8_9: rd=%b disp=%b, required 0 1", round_read_val, disp_val);
        end
    endtask

    // Fill the next bank with ones, then hold the final write for three
    // more cycles; exactly one swap must result.
    task automatic test_engine();
        int pulses;
        pulses = 0;
        round_read_pos = 24'd3;
        disp_pos = 24'd3;
        live = 1'b1;
        wden = 1'b1;
        for (int i = 0; i < 25; i++) begin
            round_write_pos = 24'(i);
            step();
            if (gen_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || round_read_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_swap: pulses=%0d rd=%b, required 0 0", pulses, round_read_val);
        end
        step();
        checks++;
        if (gen_done !== 1'b1 || gen_count !== 12'd1) begin
            errors++;
            $display("[TB] FAIL swap1: gen_done=%b gen_count=%0d, required 1 1", gen_done, gen_count);
        end
        pulses = 1;
        step();
        if (gen_done === 1'b1) pulses++;
        checks++;
        if (round_read_val !== 1'b1 || disp_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_swap_read: rd=%b disp=%b, required 1 1", round_read_val, disp_val);
        end
        step();
        if (gen_done === 1'b1) pulses++;
        wden = 1'b0;
        repeat (3) begin
            step();
            if (gen_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1 || gen_count !== 12'd1) begin
            errors++;
            $display("[TB] FAIL hold_last: pulses=%0d gen_count=%0d, required 1 1", pulses, gen_count);
        end
    endtask

    task automatic test_second_swap();
        wden = 1'b1;
        live = 1'b1;
        round_write_pos = 24'd5;
        step();
        round_write_pos = 24'd24;
        step();
        wden = 1'b0;
        round_read_pos = 24'd3;
        disp_pos = 24'd7;
        step();
        checks++;
        if (gen_done !== 1'b1 || gen_count !== 12'd2) begin
            errors++;
            $display("[TB] FAIL swap2: gen_done=%b gen_count=%0d, required 1 2", gen_done, gen_count);
        end
        step();
        checks++;
        if (gen_done !== 1'b0 || round_read_val !== 1'b0 || disp_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bank0_back: gen_done=%b rd=%b disp=%b, required 0 0 1",
                     gen_done, round_read_val, disp_val);
        end
        round_read_pos = 24'd5;
        step();
        checks++;
        if (round_read_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bank0_pos5: rd=%b, required 1", round_read_val);
        end
    endtask

    task automatic test_out_of_range();
        int pulses;
        pulses = 0;
        wden = 1'b1;
        live = 1'b1;
        round_write_pos = 24'd30;
        step();
        round_write_pos = 24'd24;
        step();
        wden = 1'b0;
        round_read_pos = 24'd30;
        disp_pos = 24'd30;
        repeat (3) begin
            step();
            if (gen_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || gen_count !== 12'd2) begin
            errors++;
            $display("[TB] FAIL range_noswap: pulses=%0d gen_count=%0d, required 0 2", pulses, gen_count);
        end
        checks++;
        if (round_read_val !== 1'b0 || disp_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL range_read: rd=%b disp=%b, required 0 0", round_read_val, disp_val);
        end
    endtask

    task automatic test_start_mid();
        int n;
        int pulses;
        wden = 1'b1;
        live = 1'b1;
        for (int i = 0; i < 12; i++) begin
            round_write_pos = 24'(i);
            step();
        end
        wden = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || gen_count !== '0) begin
            errors++;
            $display("[TB] FAIL start_enter: busy=%b gen_count=%0d, required 1 0", busy, gen_count);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n !== 25) begin
            errors++;
            $display("[TB] FAIL start_sweep_len: got %0d cycles, required 25", n);
        end
        round_read_pos = 24'd7;
        disp_pos = 24'd5;
        step();
        checks++;
        if (round_read_val !== 1'b0 || disp_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cleared_reads: rd=%b disp=%b, required 0 0", round_read_val, disp_val);
        end
        pulses = 0;
        wden = 1'b1;
        round_write_pos = 24'd24;
        step();
        wden = 1'b0;
        repeat (3) begin
            step();
            if (gen_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || gen_count !== '0) begin
            errors++;
            $display("[TB] FAIL unarmed_last: pulses=%0d gen_count=%0d, required 0 0", pulses, gen_count);
        end
    endtask

    // Start rises while a swap is pending; clear must win. A second start
    // edge mid-sweep restarts the sweep from the beginning.
    task automatic test_start_collision();
        int n;
        wden = 1'b1;
        live = 1'b1;
        round_write_pos = 24'd1;
        step();
        round_write_pos = 24'd24;
        step();
        wden = 1'b0;
        start = 1'b1;
        step();
        checks++;
        if (gen_done !== 1'b0 || gen_count !== '0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision: gen_done=%b gen_count=%0d busy=%b, required 0 0 1",
                     gen_done, gen_count, busy);
        end
        start = 1'b0;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n !== 25 || gen_count !== '0) begin
            errors++;
            $display("[TB] FAIL restart_sweep: got %0d cycles gen_count=%0d, required 25 0", n, gen_count);
        end
    endtask

    initial begin
        test_reset();
        test_edit();
        test_engine();
        test_second_swap();
        test_out_of_range();
        test_start_mid();
        test_start_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
